// File: rtl/vga_pkg.sv
// Shared VGA timing constants and small decode helpers.
package vga_pkg;

    localparam int unsigned CntW       = 10;
    localparam int unsigned FrameCntW  = 8;

    // 640x480 @ 60 Hz defaults, in pixels / lines.
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // True when val lies in [lo, lo+len), unsigned CntW-bit compare.
    function automatic logic in_window(logic [CntW-1:0] val, int unsigned lo, int unsigned len);
        logic [CntW-1:0] lo_v;
        logic [CntW-1:0] hi_v;
        lo_v = CntW'(lo);
        hi_v = CntW'(lo + len);
        return (val >= lo_v) && (val < hi_v);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the VGA generator, bundled for the color/sprite consumers.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic                 pixel_clk;
    logic [CntW-1:0]      draw_x;
    logic [CntW-1:0]      draw_y;
    logic                 blank;
    logic                 hs;
    logic                 vs;
    logic                 hs_d;
    logic                 vs_d;
    logic                 sync;
    logic                 frame_tick;
    logic                 line_tick;
    logic [FrameCntW-1:0] frame_count;

    modport master (
        output pixel_clk, draw_x, draw_y, blank, hs, vs, hs_d, vs_d, sync,
               frame_tick, line_tick, frame_count
    );

    modport slave (
        input pixel_clk, draw_x, draw_y, blank, hs, vs, hs_d, vs_d, sync,
              frame_tick, line_tick, frame_count
    );

endinterface

// File: rtl/sync_counter.sv
// Mod-N counter with enable, wrap flag and active/sync decode of its next value.
module sync_counter
    import vga_pkg::*;
#(
    parameter int unsigned Active     = H_ACTIVE_DEF,
    parameter int unsigned FrontPorch = H_FP_DEF,
    parameter int unsigned SyncWidth  = H_SYNC_DEF,
    parameter int unsigned BackPorch  = H_BP_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    output logic [CntW-1:0] count_o,
    output logic            wrap_o,
    output logic            active_nxt_o,
    output logic            sync_nxt_o
);

    localparam int unsigned     Total   = Active + FrontPorch + SyncWidth + BackPorch;
    localparam logic [CntW-1:0] LastVal = CntW'(Total - 1);
    localparam logic [CntW-1:0] ActEnd  = CntW'(Active);

    logic [CntW-1:0] count_q, count_d;

    // Next count and decode; decode looks at the next value so registered
    // outputs line up with the count they describe.
    always_comb begin
        count_d = count_q;
        wrap_o  = en_i && (count_q == LastVal);
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
        active_nxt_o = (count_d < ActEnd);
        sync_nxt_o   = in_window(count_d, Active + FrontPorch, SyncWidth);
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, X/Y counters, blank/sync, ticks, frame count.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    vga_timing_gen_if.master vga_o
);

    logic                 pixel_clk_q, pixel_clk_d;
    logic                 blank_q, blank_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic                 hs_dly_q, hs_dly_d;
    logic                 vs_dly_q, vs_dly_d;
    logic                 line_tick_q, line_tick_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [FrameCntW-1:0] frame_count_q, frame_count_d;

    logic            step;
    logic [CntW-1:0] h_count, v_count;
    logic            h_wrap, v_wrap;
    logic            h_act_nxt, v_act_nxt;
    logic            h_sync_nxt, v_sync_nxt;

    // A pixel step is any edge where the pixel enable is already high.
    assign step = pixel_clk_q;

    sync_counter #(
        .Active     (H_ACTIVE),
        .FrontPorch (H_FP),
        .SyncWidth  (H_SYNC),
        .BackPorch  (H_BP)
    ) u_h_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (step),
        .count_o      (h_count),
        .wrap_o       (h_wrap),
        .active_nxt_o (h_act_nxt),
        .sync_nxt_o   (h_sync_nxt)
    );

    sync_counter #(
        .Active     (V_ACTIVE),
        .FrontPorch (V_FP),
        .SyncWidth  (V_SYNC),
        .BackPorch  (V_BP)
    ) u_v_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (h_wrap),
        .count_o      (v_count),
        .wrap_o       (v_wrap),
        .active_nxt_o (v_act_nxt),
        .sync_nxt_o   (v_sync_nxt)
    );

    // Next-state for outputs. blank/hs/vs only move on pixel steps, which keeps
    // blank low after reset until the first step.
    always_comb begin
        pixel_clk_d = ~pixel_clk_q;
        blank_d     = blank_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        hs_dly_d    = hs_dly_q;
        vs_dly_d    = vs_dly_q;
        if (step) begin
            blank_d  = h_act_nxt & v_act_nxt;
            hs_d     = ~h_sync_nxt;
            vs_d     = ~v_sync_nxt;
            hs_dly_d = hs_q;
            vs_dly_d = vs_q;
        end
        // h_wrap already implies a pixel step.
        line_tick_d   = h_wrap;
        frame_tick_d  = h_wrap & v_wrap;
        frame_count_d = frame_count_q + {{(FrameCntW-1){1'b0}}, frame_tick_d};
    end

    // Output and pixel-enable registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pixel_clk_q   <= 1'b0;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_dly_q      <= 1'b1;
            vs_dly_q      <= 1'b1;
            line_tick_q   <= 1'b0;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            pixel_clk_q   <= pixel_clk_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            line_tick_q   <= line_tick_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga_o.pixel_clk   = pixel_clk_q;
    assign vga_o.draw_x      = h_count;
    assign vga_o.draw_y      = v_count;
    assign vga_o.blank       = blank_q;
    assign vga_o.hs          = hs_q;
    assign vga_o.vs          = vs_q;
    assign vga_o.hs_d        = hs_dly_q;
    assign vga_o.vs_d        = vs_dly_q;
    assign vga_o.sync        = 1'b0;
    assign vga_o.frame_tick  = frame_tick_q;
    assign vga_o.line_tick   = line_tick_q;
    assign vga_o.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing DUT and a tiny-timing DUT side by side,
// both compared every cycle against a closed-form raster model.
module tb_vga_timing_gen;

    // Tiny raster: 8 x 6 positions, 96 CLK per frame.
    localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
    localparam int SFRAME = 2 * (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    vga_timing_gen dut_d (
        .clk_i (clk),
        .rst_i (rst),
        .vga_o (if_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .vga_o (if_s)
    );

    // {pixel_clk, x, y, blank, hs, vs, hs_d, vs_d, sync, frame_tick, line_tick, frame_count}
    logic [36:0] obs_d, obs_s;
    assign obs_d = {if_d.pixel_clk, if_d.draw_x, if_d.draw_y, if_d.blank, if_d.hs, if_d.vs,
                    if_d.hs_d, if_d.vs_d, if_d.sync, if_d.frame_tick, if_d.line_tick,
                    if_d.frame_count};
    assign obs_s = {if_s.pixel_clk, if_s.draw_x, if_s.draw_y, if_s.blank, if_s.hs, if_s.vs,
                    if_s.hs_d, if_s.vs_d, if_s.sync, if_s.frame_tick, if_s.line_tick,
                    if_s.frame_count};

    int total = 0;
    int bad = 0;
    int n_edges = 0;  // clock edges since reset release

    // Expected outputs after n edges since reset release. Every two edges is one
    // pixel step; position is the step count modulo the frame size.
    function automatic logic [36:0] model(int n, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vb);
        int ht, vt, tot, s, p, x, y, q, px, py, fc;
        logic bl, hs, vs, hsd, vsd, stepped, lt, ft;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        tot = ht * vt;
        s   = n / 2;
        p   = s % tot;
        x   = p % ht;
        y   = p / ht;
        bl  = (s == 0) ? 1'b0 : ((x < ha) && (y < va));
        hs  = !((x >= ha + hf) && (x < ha + hf + hsw));
        vs  = !((y >= va + vf) && (y < va + vf + vsw));
        if (s == 0) begin
            hsd = 1'b1;
            vsd = 1'b1;
        end else begin
            q   = (s - 1) % tot;
            px  = q % ht;
            py  = q / ht;
            hsd = !((px >= ha + hf) && (px < ha + hf + hsw));
            vsd = !((py >= va + vf) && (py < va + vf + vsw));
        end
        stepped = (n > 0) && (n % 2 == 0);
        lt = stepped && (x == 0);
        ft = stepped && (p == 0);
        fc = (s / tot) % 256;
        return {1'(n % 2), 10'(x), 10'(y), bl, hs, vs, hsd, vsd, 1'b0, ft, lt, 8'(fc)};
    endfunction

    function automatic logic [36:0] mdl_d(int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [36:0] mdl_s(int n);
        return model(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    endfunction

    // One clock; returns at the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (!rst) n_edges++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        n_edges = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        n_edges = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_d !== mdl_d(0)) begin
                bad++;
                $display("FAIL reset_default got=%h exp=%h", obs_d, mdl_d(0));
            end
            total++;
            if (obs_s !== mdl_s(0)) begin
                bad++;
                $display("FAIL reset_small got=%h exp=%h", obs_s, mdl_s(0));
            end
        end
    endtask

    // Two full default lines: per-cycle model check plus line-level counts.
    task automatic test_line();
        int lt_cnt = 0;
        int hs_low = 0;
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            tick();
            total++;
            if (obs_d !== mdl_d(n_edges)) begin
                bad++;
                $display("FAIL line_cycle n=%0d got=%h exp=%h", n_edges, obs_d, mdl_d(n_edges));
            end
            if (if_d.line_tick) lt_cnt++;
            if (!if_d.hs) hs_low++;
        end
        total++;
        if (if_d.draw_x !== 10'd0 || if_d.draw_y !== 10'd1) begin
            bad++;
            $display("FAIL line_end got=%0d,%0d exp=0,1", if_d.draw_x, if_d.draw_y);
        end
        total++;
        if (lt_cnt != 1) begin
            bad++;
            $display("FAIL line_tick_count got=%0d exp=1", lt_cnt);
        end
        total++;
        if (hs_low != 192) begin
            bad++;
            $display("FAIL hs_low_cycles got=%0d exp=192", hs_low);
        end
    endtask

    // DrawX 655 -> 656: hs falls with the step, hs_d one step later.
    task automatic test_hs_edge();
        do_reset();
        while (n_edges < 1311) tick();
        total++;
        if (if_d.draw_x !== 10'd655 || if_d.hs !== 1'b1) begin
            bad++;
            $display("FAIL hs_before got=x%0d hs%b exp=x655 hs1", if_d.draw_x, if_d.hs);
        end
        tick();
        total++;
        if (if_d.draw_x !== 10'd656 || if_d.hs !== 1'b0 || if_d.hs_d !== 1'b1) begin
            bad++;
            $display("FAIL hs_fall got=x%0d hs%b hs_d%b exp=x656 hs0 hs_d1",
                     if_d.draw_x, if_d.hs, if_d.hs_d);
        end
        tick();
        tick();
        total++;
        if (if_d.draw_x !== 10'd657 || if_d.hs_d !== 1'b0) begin
            bad++;
            $display("FAIL hs_d_fall got=x%0d hs_d%b exp=x657 hs_d0", if_d.draw_x, if_d.hs_d);
        end
    endtask

    // One tiny frame plus a little: single frame_tick and frame_count=1.
    task automatic test_frame();
        int ft_cnt = 0;
        do_reset();
        for (int i = 0; i < SFRAME + 4; i++) begin
            tick();
            total++;
            if (obs_s !== mdl_s(n_edges)) begin
                bad++;
                $display("FAIL frame_cycle n=%0d got=%h exp=%h", n_edges, obs_s, mdl_s(n_edges));
            end
            if (if_s.frame_tick) begin
                ft_cnt++;
                total++;
                if (!if_s.line_tick) begin
                    bad++;
                    $display("FAIL frame_line_tick got=0 exp=1");
                end
            end
        end
        total++;
        if (ft_cnt != 1 || if_s.frame_count !== 8'd1) begin
            bad++;
            $display("FAIL frame_once got=ticks%0d cnt%0d exp=ticks1 cnt1",
                     ft_cnt, ft_cnt, if_s.frame_count);
        end
    endtask

    // Reset asserted mid-frame at a random point: immediate return to reset state, no ticks.
    task automatic test_mid_reset();
        int stop;
        do_reset();
        stop = 2 * $urandom_range(10, 200) + $urandom_range(0, 1);
        while (n_edges < stop) tick();
        rst = 1'b1;
        n_edges = 0;
        #1;
        total++;
        if (obs_s !== mdl_s(0) || obs_d !== mdl_d(0)) begin
            bad++;
            $display("FAIL midreset_async got=%h/%h exp=%h/%h", obs_d, obs_s, mdl_d(0), mdl_s(0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_s !== mdl_s(0) || obs_d !== mdl_d(0)) begin
                bad++;
                $display("FAIL midreset_hold got=%h/%h exp=%h/%h",
                         obs_d, obs_s, mdl_d(0), mdl_s(0));
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (obs_s !== mdl_s(n_edges) || obs_d !== mdl_d(n_edges)) begin
                bad++;
                $display("FAIL midreset_resume n=%0d got=%h/%h exp=%h/%h", n_edges,
                         obs_d, obs_s, mdl_d(n_edges), mdl_s(n_edges));
            end
        end
    endtask

    // 256 tiny frames: frame_count reaches 255 then wraps to 0 on the 256th tick.
    task automatic test_frame_wrap();
        int ft_cnt = 0;
        do_reset();
        for (int i = 0; i < 256 * SFRAME + 2; i++) begin
            tick();
            total++;
            if (obs_s !== mdl_s(n_edges)) begin
                bad++;
                $display("FAIL wrap_cycle n=%0d got=%h exp=%h", n_edges, obs_s, mdl_s(n_edges));
            end
            if (if_s.frame_tick) begin
                ft_cnt++;
                if (ft_cnt == 255) begin
                    total++;
                    if (if_s.frame_count !== 8'd255) begin
                        bad++;
                        $display("FAIL wrap_255 got=%0d exp=255", if_s.frame_count);
                    end
                end
                if (ft_cnt == 256) begin
                    total++;
                    if (if_s.frame_count !== 8'd0) begin
                        bad++;
                        $display("FAIL wrap_0 got=%0d exp=0", if_s.frame_count);
                    end
                end
            end
        end
        total++;
        if (ft_cnt != 256) begin
            bad++;
            $display("FAIL wrap_ticks got=%0d exp=256", ft_cnt);
        end
    endtask

    // Random run lengths interleaved with random-length resets.
    task automatic test_random();
        int len;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 300);
            for (int i = 0; i < len; i++) begin
                tick();
                total++;
                if (obs_s !== mdl_s(n_edges) || obs_d !== mdl_d(n_edges)) begin
                    bad++;
                    $display("FAIL random_run n=%0d got=%h/%h exp=%h/%h", n_edges,
                             obs_d, obs_s, mdl_d(n_edges), mdl_s(n_edges));
                end
            end
            rst = 1'b1;
            n_edges = 0;
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) begin
                tick();
                total++;
                if (obs_s !== mdl_s(0) || obs_d !== mdl_d(0)) begin
                    bad++;
                    $display("FAIL random_reset got=%h/%h exp=%h/%h",
                             obs_d, obs_s, mdl_d(0), mdl_s(0));
                end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hs_edge();
        test_frame();
        test_mid_reset();
        test_frame_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; port names follow the codebase.
REQ-002 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, horizontal porch and sync widths in pixels.
REQ-004 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, vertical porch and sync widths in lines.
REQ-006 The block SHALL have the following ports:
- CLK  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous reset, active-high
- pixel_clk  out  1  pixel enable, toggles every CLK cycle (25 MHz)
- DrawX  out  10  current pixel column
- DrawY  out  10  current pixel line
- blank  out  1  1 = active display area, 0 = blanking
- hs, vs  out  1 each  horizontal/vertical sync, active-low
- hs_d, vs_d  out  1 each  hs/vs delayed one pixel, aligned with a downstream registered RGB stage
- sync  out  1  constant 0
- frame_tick  out  1  one-CLK pulse per frame wrap
- line_tick  out  1  one-CLK pulse per line wrap
- frame_count  out  8  frames since reset, wrapping

Function
REQ-007 H_TOTAL SHALL be the sum of the four horizontal parameters (800), and V_TOTAL the sum of the four vertical parameters (525).
REQ-008 pixel_clk SHALL be a register that inverts on every CLK edge; a "pixel step" is a CLK edge on which pixel_clk is 1 before that edge.
REQ-009 DrawX SHALL increment by 1 on each pixel step and wrap from H_TOTAL-1 to 0.
REQ-010 DrawY SHALL increment by 1 only on a pixel step where DrawX wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-011 blank, hs and vs SHALL be registered and computed from the next-state counters, so on every cycle they describe the current DrawX/DrawY:
- blank = (DrawX < H_ACTIVE) and (DrawY < V_ACTIVE)
- hs = 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751)
- vs = 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491)
REQ-012 On each pixel step, hs_d and vs_d SHALL load the values hs and vs held before that edge; they hold between pixel steps.
REQ-013 line_tick SHALL be 1 for exactly the CLK cycle following a pixel step in which DrawX wrapped to 0, and 0 otherwise.
REQ-014 frame_tick SHALL be 1 for exactly the CLK cycle following a pixel step in which (DrawX,DrawY) wrapped from (799,524) to (0,0); line_tick SHALL also be 1 in that cycle.
REQ-015 frame_count SHALL increment by 1 in the same cycle frame_tick rises, wrapping 255 to 0.
REQ-016 All counter compares SHALL be unsigned 10-bit; the counters SHALL never hold a value at or above H_TOTAL or V_TOTAL.

Reset
REQ-017 While Reset=1, the outputs SHALL hold the following values:
- pixel_clk=0, DrawX=0, DrawY=0
- blank=0, hs=1, vs=1, hs_d=1, vs_d=1
- line_tick=0, frame_tick=0, frame_count=0
REQ-018 blank=0 after reset SHALL be the only exception to REQ-011, and it SHALL hold until the first pixel step.
REQ-019 Reset asserted mid-frame SHALL return all state to the REQ-017 values immediately, without producing a tick pulse.
REQ-020 After Reset falls, the first pixel step SHALL occur on the second CLK edge, giving DrawX=1 and blank=1.

Structure
REQ-021 The timing defaults and the derived H_TOTAL and V_TOTAL SHALL be constants in a shared package, vga_pkg, also used by the color and sprite logic.
REQ-022 A single sub-module, sync_counter, SHALL be instantiated twice (horizontal and vertical), each being a mod-N counter with enable, wrap flag and sync/active decode.

Verification
REQ-023 Release reset, run 2*800 CLK cycles -> DrawX counts 0..799, wraps to 0, DrawY=1, and line_tick pulses once.
REQ-024 Scan one full line -> hs=0 for exactly DrawX 656..751 (96 pixels = 192 CLK); blank=1 for DrawX 0..639 and 0 for DrawX 640..799.
REQ-025 Run one full frame (840000 CLK) -> vs=0 only on DrawY 490..491, frame_tick pulses once for one CLK at wrap to (0,0), and frame_count=1.
REQ-026 Step the pixel at DrawX=655 -> 656 -> hs falls in the same cycle; hs_d falls one pixel step later.
REQ-027 Assert Reset at (DrawX=300, DrawY=200) for 3 cycles -> all outputs hold the REQ-017 values, with no frame_tick or line_tick pulse.
REQ-028 Run 256 frames -> frame_count wraps from 255 to 0 on the 256th frame_tick.
